// File: rtl/ir_cmd_scheduler.sv
// IR command scheduler: decodes UART bytes into IR command codes, buffers them
// in a small FIFO and plays each one as a fixed enable burst followed by a gap.
module ir_cmd_scheduler #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2000,
  parameter int GAP_CYCLES  = 500,
  parameter int CNT_W       = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_done,
  input  logic [7:0]               rx_data,
  output logic                     enable,
  output logic [2:0]               conduct,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             enableNext;
  logic [2:0]       conductNext;

  logic [2:0]       mem [DEPTH];
  logic [AW-1:0]    rdPtr, wrPtr;
  logic [2:0]       rxCode;
  logic             abortCmd;
  logic             fifoEmpty, fifoFull;
  logic             push, pop;

  // Byte decode; ABORT is a separate strobe and never becomes a queued code.
  always_comb begin
    rxCode   = 3'd0;
    abortCmd = 1'b0;
    if (rx_done) begin
      case (rx_data)
        8'd55:   rxCode = 3'd1;
        8'd56:   rxCode = 3'd2;
        8'd99:   rxCode = 3'd3;
        8'd100:  rxCode = 3'd4;
        8'd27:   abortCmd = 1'b1;
        default: rxCode = 3'd0;
      endcase
    end
  end

  assign fifoEmpty = (fifo_count == '0);
  assign fifoFull  = (fifo_count == CW'(DEPTH));
  assign push      = (rxCode != 3'd0) && (!fifoFull || pop);
  assign busy      = (state != IDLE) || !fifoEmpty;

  // Next-state logic; the end of a gap pops directly into HOLD so that
  // consecutive commands are separated by exactly GAP_CYCLES low cycles.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    enableNext  = enable;
    conductNext = conduct;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty && !abortCmd) begin
          pop         = 1'b1;
          stateNext   = HOLD;
          enableNext  = 1'b1;
          conductNext = mem[rdPtr];
          cntNext     = '0;
        end
      end
      HOLD: begin
        if (abortCmd || cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          stateNext   = GAP;
          enableNext  = 1'b0;
          conductNext = 3'd0;
          cntNext     = '0;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cntNext = '0;
          if (!fifoEmpty && !abortCmd) begin
            pop         = 1'b1;
            stateNext   = HOLD;
            enableNext  = 1'b1;
            conductNext = mem[rdPtr];
          end else begin
            stateNext = IDLE;
          end
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext   = IDLE;
        enableNext  = 1'b0;
        conductNext = 3'd0;
        cntNext     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      enable  <= 1'b0;
      conduct <= 3'd0;
      drop    <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      enable  <= enableNext;
      conduct <= conductNext;
      drop    <= (rxCode != 3'd0) && fifoFull && !pop;
    end
  end

  // ABORT flushes the queue; otherwise push and pop update pointers and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      fifo_count <= '0;
    end else if (abortCmd) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wrPtr <= (wrPtr == AW'(DEPTH - 1)) ? '0 : wrPtr + AW'(1);
      if (pop)
        rdPtr <= (rdPtr == AW'(DEPTH - 1)) ? '0 : rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !abortCmd)
      mem[wrPtr] <= rxCode;
  end

endmodule
